// File: rtl/decode_instruction_pkg.sv
// ---------------------------------------------------------------------------
// decode_instruction_pkg : widths, opcodes, field positions and FSM encoding
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package decode_instruction_pkg;

    localparam int WORD  = 32;
    localparam int ADDR  = 32;
    localparam int RADDR = 5;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_AND  = 6'h03;
    localparam logic [5:0] OP_OR   = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LD   = 6'h10;
    localparam logic [5:0] OP_ST   = 6'h11;
    localparam logic [5:0] OP_BEQ  = 6'h18;
    localparam logic [5:0] OP_JMP  = 6'h19;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RD_MSB  = 25;
    localparam int RD_LSB  = 21;
    localparam int RS_MSB  = 20;
    localparam int RS_LSB  = 16;
    localparam int RT_MSB  = 15;
    localparam int RT_LSB  = 11;
    localparam int IMM_MSB = 15;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BUBBLE = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/decode_instruction_op_decoder.sv
// ---------------------------------------------------------------------------
// decode_instruction_op_decoder : combinational opcode -> control flags
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module decode_instruction_op_decoder
    import decode_instruction_pkg::*;
(
    input  logic [5:0] i_opcode,
    output logic       o_we,
    output logic       o_mem_re,
    output logic       o_mem_we,
    output logic       o_br,
    output logic       o_jmp,
    output logic       o_uses_rt,
    output logic       o_illegal
);

    always_comb begin
        o_we      = 1'b0;
        o_mem_re  = 1'b0;
        o_mem_we  = 1'b0;
        o_br      = 1'b0;
        o_jmp     = 1'b0;
        o_uses_rt = 1'b0;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_NOP, OP_HALT: ;
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                o_we      = 1'b1;
                o_uses_rt = 1'b1;
            end
            OP_ADDI: o_we = 1'b1;
            OP_LD: begin
                o_we     = 1'b1;
                o_mem_re = 1'b1;
            end
            OP_ST: begin
                o_mem_we  = 1'b1;
                o_uses_rt = 1'b1;
            end
            OP_BEQ: begin
                o_br      = 1'b1;
                o_uses_rt = 1'b1;
            end
            OP_JMP:  o_jmp     = 1'b1;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/decode_instruction.sv
// ---------------------------------------------------------------------------
// decode_instruction : decode stage with load-use bubble, flush, stall, HALT
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module decode_instruction
    import decode_instruction_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             v_i,
    input  logic [WORD-1:0]  inst_i,
    input  logic [ADDR-1:0]  pc_i,
    input  logic             stall_i,
    output logic             stall_o,
    input  logic             branch,
    output logic [RADDR-1:0] rs_addr_o,
    output logic [RADDR-1:0] rt_addr_o,
    output logic             v_o,
    output logic [5:0]       opcode_o,
    output logic [RADDR-1:0] rd_o,
    output logic [RADDR-1:0] rs_o,
    output logic [RADDR-1:0] rt_o,
    output logic [WORD-1:0]  imm_o,
    output logic [ADDR-1:0]  pc_o,
    output logic             we_o,
    output logic             mem_re_o,
    output logic             mem_we_o,
    output logic             br_o,
    output logic             jmp_o,
    output logic             illegal_o,
    output logic             halted_o
);

    state_t           r_state;
    logic [5:0]       r_flags;

    logic [5:0]       w_opcode;
    logic [RADDR-1:0] w_rd;
    logic [RADDR-1:0] w_rs;
    logic [RADDR-1:0] w_rt;
    logic [WORD-1:0]  w_imm;
    logic             w_we;
    logic             w_mem_re;
    logic             w_mem_we;
    logic             w_br;
    logic             w_jmp;
    logic             w_uses_rt;
    logic             w_illegal;
    logic             w_hazard;

    assign w_opcode = inst_i[OPC_MSB:OPC_LSB];
    assign w_rd     = inst_i[RD_MSB:RD_LSB];
    assign w_rs     = inst_i[RS_MSB:RS_LSB];
    assign w_rt     = inst_i[RT_MSB:RT_LSB];
    assign w_imm    = {{(WORD-IMM_MSB-1){inst_i[IMM_MSB]}}, inst_i[IMM_MSB:0]};

    assign rs_addr_o = w_rs;
    assign rt_addr_o = w_rt;

    decode_instruction_op_decoder u_op_decoder (
        .i_opcode  (w_opcode),
        .o_we      (w_we),
        .o_mem_re  (w_mem_re),
        .o_mem_we  (w_mem_we),
        .o_br      (w_br),
        .o_jmp     (w_jmp),
        .o_uses_rt (w_uses_rt),
        .o_illegal (w_illegal)
    );

    // r_flags is cleared whenever v_o drops, so mem_re_o alone marks a live load
    assign w_hazard = v_i & v_o & mem_re_o & (rd_o != '0) &
                      ((rd_o == w_rs) | (w_uses_rt & (rd_o == w_rt)));

    assign stall_o = stall_i | (r_state == ST_HALTED) |
                     ((r_state == ST_RUN) & w_hazard);

    assign {we_o, mem_re_o, mem_we_o, br_o, jmp_o, illegal_o} = r_flags;
    assign halted_o = (r_state == ST_HALTED);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_RUN;
            r_flags  <= '0;
            v_o      <= 1'b0;
            opcode_o <= '0;
            rd_o     <= '0;
            rs_o     <= '0;
            rt_o     <= '0;
            imm_o    <= '0;
            pc_o     <= '0;
        end else if (stall_i) begin
            r_state <= r_state;
        end else if (r_state == ST_HALTED) begin
            v_o     <= 1'b0;
            r_flags <= '0;
        end else if (branch) begin
            v_o     <= 1'b0;
            r_flags <= '0;
            r_state <= ST_RUN;
        end else if ((r_state == ST_RUN) && w_hazard) begin
            v_o     <= 1'b0;
            r_flags <= '0;
            r_state <= ST_BUBBLE;
        end else if (v_i) begin
            v_o      <= 1'b1;
            r_flags  <= {w_we, w_mem_re, w_mem_we, w_br, w_jmp, w_illegal};
            opcode_o <= w_opcode;
            rd_o     <= w_rd;
            rs_o     <= w_rs;
            rt_o     <= w_rt;
            imm_o    <= w_imm;
            pc_o     <= pc_i;
            r_state  <= (w_opcode == OP_HALT) ? ST_HALTED : ST_RUN;
        end else begin
            v_o     <= 1'b0;
            r_flags <= '0;
            r_state <= ST_RUN;
        end
    end

endmodule

`default_nettype wire
